// File: rtl/traffic_phase_ctrl.sv
// Traffic-light phase sequencer: times each phase in timer ticks and can end a
// green early to insert an all-red pedestrian walk phase.
module traffic_phase_ctrl #(
   parameter int unsigned GREEN_T     = 10,
   parameter int unsigned YELLOW_T    = 3,
   parameter int unsigned CLEAR_T     = 1,
   parameter int unsigned WALK_T      = 5,
   parameter int unsigned MIN_GREEN_T = 4,
   parameter int unsigned CW          = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   input  logic          ped_req,
   output logic [2:0]    ns_light,
   output logic [2:0]    ew_light,
   output logic          walk,
   output logic          ped_ack,
   output logic [CW-1:0] phase_rem
);

   typedef enum logic [2:0] {
      NS_G = 3'd0,
      NS_Y = 3'd1,
      CLR  = 3'd2,
      EW_G = 3'd3,
      EW_Y = 3'd4,
      WALK = 3'd5
   } state_e;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   localparam logic [CW-1:0] GREEN_C  = CW'(GREEN_T);
   localparam logic [CW-1:0] YELLOW_C = CW'(YELLOW_T);
   localparam logic [CW-1:0] CLEAR_C  = CW'(CLEAR_T);
   localparam logic [CW-1:0] WALK_C   = CW'(WALK_T);
   localparam logic [CW-1:0] ONE_C    = CW'(1);
   // A pending request may end green once this many ticks or fewer remain.
   localparam logic [CW-1:0] EARLY_C  = CW'(GREEN_T - MIN_GREEN_T + 1);

   state_e        state_q, state_d;
   logic          dir_q, dir_d;
   logic [CW-1:0] rem_q, rem_d;
   logic          ped_pend_q, ped_pend_d;
   logic [2:0]    ns_light_q, ns_light_d;
   logic [2:0]    ew_light_q, ew_light_d;
   logic          walk_q, walk_d;

   function automatic logic [CW-1:0] duration(input state_e s);
      case (s)
         NS_G, EW_G: duration = GREEN_C;
         NS_Y, EW_Y: duration = YELLOW_C;
         WALK:       duration = WALK_C;
         default:    duration = CLEAR_C;
      endcase
   endfunction

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= NS_G;
         dir_q      <= 1'b1;
         rem_q      <= GREEN_C;
         ped_pend_q <= 1'b0;
         ns_light_q <= GRN;
         ew_light_q <= RED;
         walk_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         rem_q      <= rem_d;
         ped_pend_q <= ped_pend_d;
         ns_light_q <= ns_light_d;
         ew_light_q <= ew_light_d;
         walk_q     <= walk_d;
      end
   end

   // Next-state, phase counter and request latch.
   // NOTE: every signal gets a default first so no path through the case
   // leaves one unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      if (tick) begin
         case (state_q)
            NS_G: if (rem_q == ONE_C || (ped_pend_q && rem_q <= EARLY_C)) state_d = NS_Y;
            EW_G: if (rem_q == ONE_C || (ped_pend_q && rem_q <= EARLY_C)) state_d = EW_Y;
            NS_Y: if (rem_q == ONE_C) begin
               state_d = CLR;
               dir_d   = 1'b1;
            end
            EW_Y: if (rem_q == ONE_C) begin
               state_d = CLR;
               dir_d   = 1'b0;
            end
            CLR: if (rem_q == ONE_C) begin
               if (ped_pend_q) state_d = WALK;
               else            state_d = dir_q ? EW_G : NS_G;
            end
            WALK: if (rem_q == ONE_C) state_d = dir_q ? EW_G : NS_G;
            default: state_d = NS_G;
         endcase
      end

      if (state_d != state_q)  rem_d = duration(state_d);
      else if (tick)           rem_d = rem_q - ONE_C;
      else                     rem_d = rem_q;

      // A request arriving on the WALK-entry cycle survives the clear.
      if (state_d == WALK && state_q != WALK) ped_pend_d = ped_req;
      else                                    ped_pend_d = ped_pend_q | ped_req;
   end

   // Light decode from the next state so the registered heads track the state.
   always_comb begin
      ns_light_d = RED;
      ew_light_d = RED;
      walk_d     = 1'b0;
      case (state_d)
         NS_G:    ns_light_d = GRN;
         NS_Y:    ns_light_d = YEL;
         EW_G:    ew_light_d = GRN;
         EW_Y:    ew_light_d = YEL;
         WALK:    walk_d     = 1'b1;
         default: ;
      endcase
   end

   assign ns_light  = ns_light_q;
   assign ew_light  = ew_light_q;
   assign walk      = walk_q;
   assign ped_ack   = ped_pend_q;
   assign phase_rem = rem_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: phase timing, pedestrian insertion,
// async reset and stuck-high tick, checked against hand-derived vectors.
module tb_traffic_phase_ctrl;

   localparam int P_NSG = 0, P_NSY = 1, P_CLR = 2, P_EWG = 3, P_EWY = 4, P_WALK = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic       ped_req = 1'b0;
   logic [2:0] ns_light, ew_light;
   logic       walk, ped_ack;
   logic [7:0] phase_rem;

   int checks = 0;
   int failures = 0;

   traffic_phase_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .ped_req   (ped_req),
      .ns_light  (ns_light),
      .ew_light  (ew_light),
      .walk      (walk),
      .ped_ack   (ped_ack),
      .phase_rem (phase_rem)
   );

   always #5 clk = ~clk;

   // Observed vector {ns, ew, walk, ped_ack, phase_rem}.
   function automatic logic [15:0] obs();
      return {ns_light, ew_light, walk, ped_ack, phase_rem};
   endfunction

   function automatic logic [15:0] exp_vec(input int p, input logic ack, input int r);
      logic [2:0] ns, ew;
      logic       w;
      ns = 3'b100; ew = 3'b100; w = 1'b0;
      case (p)
         P_NSG:  ns = 3'b001;
         P_NSY:  ns = 3'b010;
         P_EWG:  ew = 3'b001;
         P_EWY:  ew = 3'b010;
         P_WALK: w  = 1'b1;
         default: ;
      endcase
      return {ns, ew, w, ack, 8'(r)};
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0; tick = 1'b0; ped_req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // One tick roughly every 4 cycles; returns on a negedge after the effect.
   task automatic do_tick(input logic req);
      @(negedge clk);
      tick = 1'b1; ped_req = req;
      @(negedge clk);
      tick = 1'b0; ped_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec(P_NSG, 1'b0, 10)) begin
         failures++;
         $display("FAIL reset_state got=%h exp=%h", obs(), exp_vec(P_NSG, 1'b0, 10));
      end
      reset = 1'b1;
   endtask

   task automatic test_normal_cycle();
      int ph[6];
      int du[6];
      ph = '{P_NSG, P_NSY, P_CLR, P_EWG, P_EWY, P_CLR};
      du = '{10, 3, 1, 10, 3, 1};
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         for (int r = du[i]; r >= 1; r--) begin
            checks++;
            if (obs() !== exp_vec(ph[i], 1'b0, r)) begin
               failures++;
               $display("FAIL normal_cycle phase=%0d rem=%0d got=%h exp=%h", i, r, obs(), exp_vec(ph[i], 1'b0, r));
            end
            do_tick(1'b0);
         end
      end
      checks++;
      if (obs() !== exp_vec(P_NSG, 1'b0, 10)) begin
         failures++;
         $display("FAIL normal_wrap got=%h exp=%h", obs(), exp_vec(P_NSG, 1'b0, 10));
      end
   endtask

   task automatic test_ped_early();
      apply_reset();
      do_tick(1'b0);
      @(negedge clk);
      tick = 1'b1; ped_req = 1'b1;
      @(negedge clk);
      tick = 1'b0; ped_req = 1'b0;
      checks++;
      if (obs() !== exp_vec(P_NSG, 1'b1, 8)) begin
         failures++;
         $display("FAIL ped_ack_latency got=%h exp=%h", obs(), exp_vec(P_NSG, 1'b1, 8));
      end
      repeat (2) @(negedge clk);
      do_tick(1'b0);
      checks++;
      if (obs() !== exp_vec(P_NSG, 1'b1, 7)) begin
         failures++;
         $display("FAIL ped_early_tick3 got=%h exp=%h", obs(), exp_vec(P_NSG, 1'b1, 7));
      end
      do_tick(1'b0);
      for (int r = 3; r >= 1; r--) begin
         checks++;
         if (obs() !== exp_vec(P_NSY, 1'b1, r)) begin
            failures++;
            $display("FAIL ped_early_nsy rem=%0d got=%h exp=%h", r, obs(), exp_vec(P_NSY, 1'b1, r));
         end
         do_tick(1'b0);
      end
      checks++;
      if (obs() !== exp_vec(P_CLR, 1'b1, 1)) begin
         failures++;
         $display("FAIL ped_early_clr got=%h exp=%h", obs(), exp_vec(P_CLR, 1'b1, 1));
      end
      do_tick(1'b0);
      for (int r = 5; r >= 1; r--) begin
         checks++;
         if (obs() !== exp_vec(P_WALK, 1'b0, r)) begin
            failures++;
            $display("FAIL ped_early_walk rem=%0d got=%h exp=%h", r, obs(), exp_vec(P_WALK, 1'b0, r));
         end
         do_tick(1'b0);
      end
      checks++;
      if (obs() !== exp_vec(P_EWG, 1'b0, 10)) begin
         failures++;
         $display("FAIL ped_early_ewg got=%h exp=%h", obs(), exp_vec(P_EWG, 1'b0, 10));
      end
   endtask

   task automatic test_ped_late();
      apply_reset();
      repeat (7) do_tick(1'b0);
      do_tick(1'b1);
      checks++;
      if (obs() !== exp_vec(P_NSG, 1'b1, 2)) begin
         failures++;
         $display("FAIL ped_late_tick8 got=%h exp=%h", obs(), exp_vec(P_NSG, 1'b1, 2));
      end
      do_tick(1'b0);
      checks++;
      if (obs() !== exp_vec(P_NSY, 1'b1, 3)) begin
         failures++;
         $display("FAIL ped_late_tick9 got=%h exp=%h", obs(), exp_vec(P_NSY, 1'b1, 3));
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      @(negedge clk);
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
      repeat (3) do_tick(1'b0);
      checks++;
      if (obs() !== exp_vec(P_NSG, 1'b1, 7)) begin
         failures++;
         $display("FAIL b2b_green got=%h exp=%h", obs(), exp_vec(P_NSG, 1'b1, 7));
      end
      repeat (4) do_tick(1'b0);
      checks++;
      if (obs() !== exp_vec(P_CLR, 1'b1, 1)) begin
         failures++;
         $display("FAIL b2b_clr got=%h exp=%h", obs(), exp_vec(P_CLR, 1'b1, 1));
      end
      do_tick(1'b1);
      checks++;
      if (obs() !== exp_vec(P_WALK, 1'b1, 5)) begin
         failures++;
         $display("FAIL b2b_walk_set_wins got=%h exp=%h", obs(), exp_vec(P_WALK, 1'b1, 5));
      end
      repeat (5) do_tick(1'b0);
      checks++;
      if (obs() !== exp_vec(P_EWG, 1'b1, 10)) begin
         failures++;
         $display("FAIL b2b_ewg got=%h exp=%h", obs(), exp_vec(P_EWG, 1'b1, 10));
      end
      repeat (4) do_tick(1'b0);
      checks++;
      if (obs() !== exp_vec(P_EWY, 1'b1, 3)) begin
         failures++;
         $display("FAIL b2b_ewy got=%h exp=%h", obs(), exp_vec(P_EWY, 1'b1, 3));
      end
      repeat (4) do_tick(1'b0);
      checks++;
      if (obs() !== exp_vec(P_WALK, 1'b0, 5)) begin
         failures++;
         $display("FAIL b2b_second_walk got=%h exp=%h", obs(), exp_vec(P_WALK, 1'b0, 5));
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      repeat (25) do_tick(1'b0);
      @(negedge clk);
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
      checks++;
      if (obs() !== exp_vec(P_EWY, 1'b1, 2)) begin
         failures++;
         $display("FAIL async_pre got=%h exp=%h", obs(), exp_vec(P_EWY, 1'b1, 2));
      end
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      checks++;
      if (obs() !== exp_vec(P_NSG, 1'b0, 10)) begin
         failures++;
         $display("FAIL async_reset got=%h exp=%h", obs(), exp_vec(P_NSG, 1'b0, 10));
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (9) do_tick(1'b0);
      checks++;
      if (obs() !== exp_vec(P_NSG, 1'b0, 1)) begin
         failures++;
         $display("FAIL async_green9 got=%h exp=%h", obs(), exp_vec(P_NSG, 1'b0, 1));
      end
      do_tick(1'b0);
      checks++;
      if (obs() !== exp_vec(P_NSY, 1'b0, 3)) begin
         failures++;
         $display("FAIL async_green10 got=%h exp=%h", obs(), exp_vec(P_NSY, 1'b0, 3));
      end
   endtask

   task automatic test_tick_stuck();
      logic [15:0] e;
      @(negedge clk);
      reset = 1'b0; ped_req = 1'b0; tick = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k < 10) e = exp_vec(P_NSG, 1'b0, 10 - k);
         else        e = exp_vec(P_NSY, 1'b0, 13 - k);
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL tick_stuck cycle=%0d got=%h exp=%h", k, obs(), e);
         end
      end
      tick = 1'b0;
   endtask

   initial begin
      test_reset();
      test_normal_cycle();
      test_ped_early();
      test_ped_late();
      test_back_to_back();
      test_async_reset();
      test_tick_stuck();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Traffic-light phase sequencer that consumes the one-cycle `tick` produced by the `timer_st` second-timer and drives the north-south and east-west signal heads plus a pedestrian walk lamp. It counts ticks to time each phase, so phase durations are expressed in seconds. A latched pedestrian request shortens the current green and inserts an all-red walk phase. It is the consumer end of the timer tick interface and sits between `timer_st` and the board light outputs.

## Interface
- `GREEN_T`, 10, green duration in ticks
- `YELLOW_T`, 3, yellow duration in ticks
- `CLEAR_T`, 1, all-red clearance duration in ticks
- `WALK_T`, 5, walk duration in ticks
- `MIN_GREEN_T`, 4, minimum green ticks before a pedestrian request may end green
- `CW`, 8, width of the remaining-time counter
- Legal parameter values: all durations ≥1, `MIN_GREEN_T` ≤ `GREEN_T`, and every duration < 2^`CW`.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `tick` input 1: timer pulse, one cycle per second. Every cycle in which `tick` is high counts as one tick.
- `ped_req` input 1: pedestrian button, sampled every cycle.
- `ns_light` output 3: {red, yellow, green}, one-hot.
- `ew_light` output 3: {red, yellow, green}, one-hot.
- `walk` output 1: walk lamp.
- `ped_ack` output 1: request-pending indicator (the `ped_pend` register).
- `phase_rem` output `CW`: ticks remaining in the current phase.

## Operation
- States: NS_G, NS_Y, CLR, EW_G, EW_Y, WALK. A `dir` register holds the next green (0 = NS, 1 = EW).
- Light outputs per state:
  - NS_G: ns=001, ew=100.
  - NS_Y: ns=010, ew=100.
  - EW_G: ns=100, ew=001.
  - EW_Y: ns=100, ew=010.
  - CLR and WALK: both heads 100.
- `walk` is 1 only in WALK.
- Sequence: NS_G → NS_Y → CLR → [WALK if `ped_pend`] → EW_G → EW_Y → CLR → [WALK] → NS_G.
  - Leaving NS_Y sets `dir`=1; leaving EW_Y sets `dir`=0.
  - CLR and WALK exit to the green selected by `dir`.
- Phase counter `rem`:
  - Loaded with the new state's duration on every state entry.
  - On a tick with `rem`==1: the state transitions.
  - On a tick with `rem`>1: `rem` decrements.
  - No tick: `rem` holds.
  - `phase_rem` = `rem`.
- Green early exit: in NS_G or EW_G, a tick with `ped_pend`=1 and `rem` ≤ `GREEN_T`−`MIN_GREEN_T`+1 ends green. This gives at least `MIN_GREEN_T` ticks of green.
- `ped_pend`:
  - Set by `ped_req`=1 in any state.
  - Cleared on entry to WALK.
  - If set and clear occur in the same cycle, set wins and the request stays pending.
- A tick with `rem`==1 in CLR and `ped_pend`=1 enters WALK. Otherwise the tick goes straight to green.

## Timing
- All outputs are registered. Each updates on the `clk` edge that samples the causing `tick`/`ped_req`, and is visible the following cycle.
- A phase of duration D lasts exactly D ticks.
- Latency from `ped_req` to `ped_ack`: 1 cycle.
- Reset (async, `reset`=0) forces:
  - state NS_G, `dir`=1, `rem`=`GREEN_T`, `ped_pend`=0
  - ns_light=001, ew_light=100, walk=0, ped_ack=0, phase_rem=`GREEN_T`
- Reset mid-phase abandons the phase immediately, including WALK.
- Counting resumes on the first tick after `reset` returns high.
- If `tick` is high on the first cycle after reset release, it counts.
- `tick` stuck high decrements once per clock cycle; no debouncing.
- `ped_req` held high is one pending request. It re-sets `ped_pend` after WALK entry only if it is still high on a later cycle.
- Both heads are never non-red simultaneously. Any other output combination is a bug.

## Test plan
- Defaults, no `ped_req`, tick every 4 cycles:
  - NS_G lasts 10 ticks, NS_Y 3, CLR 1, EW_G 10, EW_Y 3, CLR 1, then NS_G again (full cycle 28 ticks).
  - `phase_rem` counts 10..1 in each green.
- `ped_req` pulse during the 2nd NS_G tick:
  - `ped_ack`=1 the next cycle.
  - Green ends on the 4th tick, followed by 3 ticks NS_Y, 1 tick CLR, then 5 ticks of WALK with `walk`=1 and both heads 100.
  - `ped_ack` clears on WALK entry; EW_G follows.
- `ped_req` during tick 8 of NS_G: green ends on tick 9 (`rem` ≤ 7 is already met), not tick 10.
- `ped_req` asserted in the same cycle as WALK entry: `ped_pend` stays 1, and a second WALK occurs after the next EW_Y/CLR.
- Reset asserted mid-EW_Y, asynchronously between edges:
  - Outputs go to ns=001, ew=100, `phase_rem`=10, `ped_ack`=0 immediately.
  - After release, NS_G lasts 10 ticks.
- `tick` held high for 12 cycles from reset: NS_G ends after cycle 10 and NS_Y starts with `phase_rem`=3, decrementing every cycle.
